// File: rtl/rc4_stream_if.sv
// rc4_stream_if -- key-load and keystream handshake bundle for rc4_stream.
//
// Signals (directions seen from the slave, i.e. the rc4_stream block):
//   rekey      in   synchronous pulse, return to key loading
//   key_valid  in   key byte present on key_data
//   key_ready  out  block accepts a key byte
//   key_data   in   key byte, first byte = key[0]
//   key_last   in   marks the final key byte
//   key_ovf    out  sticky, loaded key exceeded MAX_KEY_BYTES
//   busy       out  INIT / KSA / drop phases in progress
//   ks_valid   out  ks_data holds a keystream byte
//   ks_ready   in   consumer takes the byte when ks_valid && ks_ready
//   ks_data    out  keystream byte
interface rc4_stream_if;
    logic       rekey;
    logic       key_valid;
    logic       key_ready;
    logic [7:0] key_data;
    logic       key_last;
    logic       key_ovf;
    logic       busy;
    logic       ks_valid;
    logic       ks_ready;
    logic [7:0] ks_data;

    modport master (
        output rekey, key_valid, key_data, key_last, ks_ready,
        input  key_ready, key_ovf, busy, ks_valid, ks_data
    );

    modport slave (
        input  rekey, key_valid, key_data, key_last, ks_ready,
        output key_ready, key_ovf, busy, ks_valid, ks_data
    );
endinterface

// File: rtl/rc4_stream.sv
// rc4_stream -- RC4 keystream generator with runtime key length,
// byte-serial key load, valid/ready keystream output and re-key.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  rc4_stream_if.slave (key load handshake, status, keystream)
//
// Parameters:
//   MAX_KEY_BYTES  key storage depth, 1..256
//   DROP_N         initial keystream bytes discarded, 0..65535
//
// Build option: define RC4_DROP_EN to discard the first DROP_N keystream
// bytes after key scheduling (3 cycles per byte, busy held high).
// Without it DROP_N is ignored.
module rc4_stream #(
    parameter int MAX_KEY_BYTES = 16,
    parameter int DROP_N        = 768
) (
    input logic         clk,
    input logic         rst,
    rc4_stream_if.slave bus
);
    localparam int KW = (MAX_KEY_BYTES > 1) ? $clog2(MAX_KEY_BYTES) : 1;
    localparam int KN = KW + 1;
    localparam logic [KN-1:0] MAX_N    = KN'(MAX_KEY_BYTES);
    localparam logic [KW-1:0] LAST_IDX = KW'(MAX_KEY_BYTES - 1);

    if (MAX_KEY_BYTES < 1 || MAX_KEY_BYTES > 256) begin : g_bad_max
        $error("rc4_stream: MAX_KEY_BYTES must be 1..256");
    end
    if (DROP_N < 0 || DROP_N > 65535) begin : g_bad_drop
        $error("rc4_stream: DROP_N must be 0..65535");
    end

    typedef enum logic [2:0] {
        ST_KEYREAD,
        ST_INIT,
        ST_KSA_J,
        ST_KSA_SW,
        ST_P1,
        ST_P2,
        ST_P3,
        ST_P4
    } state_t;

    state_t        state;
    logic [7:0]    s_mem [256];
    logic [7:0]    key_mem [MAX_KEY_BYTES];
    logic [7:0]    i;
    logic [7:0]    j;
    logic [KN-1:0] n;         // key bytes accepted, saturates at MAX_N
    logic [KW-1:0] klen_m1;   // key length minus one
    logic [KW-1:0] ki;        // tracks i mod key length during KSA
    logic          key_take;
    logic          drop_active;

    logic [7:0] s_i;
    logic [7:0] s_j;
    logic [7:0] t;
    logic [7:0] s_t;
    logic [7:0] ks_next;

    assign key_take = bus.key_valid && bus.key_ready;

    assign s_i = s_mem[i];
    assign s_j = s_mem[j];
    assign t   = s_i + s_j;
    assign s_t = s_mem[t];
    // The output byte is S[t] after the P3 swap; the swap is still pending
    // in the memory, so patch the two swapped locations here.
    assign ks_next = (t == i) ? s_j : ((t == j) ? s_i : s_t);

`ifdef RC4_DROP_EN
    logic [15:0] drop_cnt;
    assign drop_active = (drop_cnt != 16'd0);
`else
    assign drop_active = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every branch
    // reads the pre-edge values of i, j and S.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_KEYREAD;
            i             <= 8'd0;
            j             <= 8'd0;
            n             <= '0;
            klen_m1       <= '0;
            ki            <= '0;
            bus.key_ready <= 1'b1;
            bus.key_ovf   <= 1'b0;
            bus.busy      <= 1'b0;
            bus.ks_valid  <= 1'b0;
            bus.ks_data   <= 8'd0;
`ifdef RC4_DROP_EN
            drop_cnt      <= 16'd0;
`endif
        end else if (bus.rekey) begin
            // A handshake in this cycle is simply dropped with the state.
            state         <= ST_KEYREAD;
            i             <= 8'd0;
            j             <= 8'd0;
            n             <= '0;
            ki            <= '0;
            bus.key_ready <= 1'b1;
            bus.key_ovf   <= 1'b0;
            bus.busy      <= 1'b0;
            bus.ks_valid  <= 1'b0;
            bus.ks_data   <= 8'd0;
`ifdef RC4_DROP_EN
            drop_cnt      <= 16'd0;
`endif
        end else begin
            case (state)
                ST_KEYREAD: begin
                    if (key_take) begin
                        if (n < MAX_N) n <= n + 1'b1;
                        else           bus.key_ovf <= 1'b1;
                        if (bus.key_last) begin
                            klen_m1       <= (n < MAX_N) ? n[KW-1:0] : LAST_IDX;
                            i             <= 8'd0;
                            bus.key_ready <= 1'b0;
                            bus.busy      <= 1'b1;
                            state         <= ST_INIT;
                        end
                    end
                end
                ST_INIT: begin
                    if (i == 8'hFF) begin
                        i     <= 8'd0;
                        j     <= 8'd0;
                        ki    <= '0;
                        state <= ST_KSA_J;
                    end else begin
                        i <= i + 8'd1;
                    end
                end
                ST_KSA_J: begin
                    j     <= j + s_i + key_mem[ki];
                    state <= ST_KSA_SW;
                end
                ST_KSA_SW: begin
                    ki <= (ki == klen_m1) ? '0 : ki + 1'b1;
                    if (i == 8'hFF) begin
                        i     <= 8'd0;
                        j     <= 8'd0;
`ifdef RC4_DROP_EN
                        drop_cnt <= 16'(DROP_N);
`endif
                        state <= ST_P1;
                    end else begin
                        i     <= i + 8'd1;
                        state <= ST_KSA_J;
                    end
                end
                ST_P1: begin
                    i     <= i + 8'd1;
                    state <= ST_P2;
                end
                ST_P2: begin
                    j     <= j + s_i;
                    state <= ST_P3;
                end
                ST_P3: begin
                    if (drop_active) begin
`ifdef RC4_DROP_EN
                        drop_cnt <= drop_cnt - 16'd1;
`endif
                        state <= ST_P1;
                    end else begin
                        bus.ks_data  <= ks_next;
                        bus.ks_valid <= 1'b1;
                        bus.busy     <= 1'b0;
                        state        <= ST_P4;
                    end
                end
                ST_P4: begin
                    if (bus.ks_ready) begin
                        bus.ks_valid <= 1'b0;
                        state        <= ST_P1;
                    end
                end
                default: state <= ST_KEYREAD;
            endcase
        end
    end

    // NOTE: S and key storage carry no reset; their contents are rebuilt
    // by key load and INIT before ever being read.
    always_ff @(posedge clk) begin
        if (!rst && !bus.rekey) begin
            case (state)
                ST_KEYREAD: begin
                    if (key_take && (n < MAX_N)) key_mem[n[KW-1:0]] <= bus.key_data;
                end
                ST_INIT: s_mem[i] <= i;
                ST_KSA_SW, ST_P3: begin
                    s_mem[i] <= s_j;
                    s_mem[j] <= s_i;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rc4_stream.sv
// tb_rc4_stream -- self-checking bench for rc4_stream.
// Two instances: dut_a (MAX_KEY_BYTES=16) and dut_b (MAX_KEY_BYTES=3).
// Known-answer vectors come from a table; random keys and random ks_ready
// stalls are checked against a plain RC4 reference function.
module tb_rc4_stream;
`ifdef RC4_DROP_EN
    localparam int DROP = 2;
`else
    localparam int DROP = 0;
`endif
    localparam int LAT = 772 + 3 * DROP;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic [7:0] key [8];
        int         klen;
        logic [7:0] ks  [10];
        int         nks;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel_b;
    logic       rekey;
    logic       key_valid;
    logic       key_last;
    logic [7:0] key_data;
    logic       ks_ready;

    logic       o_key_ready;
    logic       o_key_ovf;
    logic       o_busy;
    logic       o_ks_valid;
    logic [7:0] o_ks_data;

    int cyc      = 0;
    int n_checks = 0;
    int n_err    = 0;

    rc4_stream_if bus_a();
    rc4_stream_if bus_b();

    assign bus_a.rekey     = rekey && !sel_b;
    assign bus_a.key_valid = key_valid && !sel_b;
    assign bus_a.key_last  = key_last;
    assign bus_a.key_data  = key_data;
    assign bus_a.ks_ready  = ks_ready && !sel_b;
    assign bus_b.rekey     = rekey && sel_b;
    assign bus_b.key_valid = key_valid && sel_b;
    assign bus_b.key_last  = key_last;
    assign bus_b.key_data  = key_data;
    assign bus_b.ks_ready  = ks_ready && sel_b;

    assign o_key_ready = sel_b ? bus_b.key_ready : bus_a.key_ready;
    assign o_key_ovf   = sel_b ? bus_b.key_ovf   : bus_a.key_ovf;
    assign o_busy      = sel_b ? bus_b.busy      : bus_a.busy;
    assign o_ks_valid  = sel_b ? bus_b.ks_valid  : bus_a.ks_valid;
    assign o_ks_data   = sel_b ? bus_b.ks_data   : bus_a.ks_data;

    rc4_stream #(.MAX_KEY_BYTES(16), .DROP_N(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    rc4_stream #(.MAX_KEY_BYTES(3),  .DROP_N(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Straight RC4 from its definition: KSA, then PRGA with optional drop.
    function automatic bq_t rc4_ref(input bq_t key, input int max_kb, input int drop, input int n);
        logic [7:0] s [256];
        logic [7:0] tmp;
        int kl;
        int ii;
        int jj;
        bq_t r;
        kl = (key.size() < max_kb) ? key.size() : max_kb;
        for (int x = 0; x < 256; x++) s[x] = x[7:0];
        jj = 0;
        for (int x = 0; x < 256; x++) begin
            jj = (jj + s[x] + key[x % kl]) % 256;
            tmp = s[x]; s[x] = s[jj]; s[jj] = tmp;
        end
        ii = 0;
        jj = 0;
        for (int b = 0; b < drop + n; b++) begin
            ii = (ii + 1) % 256;
            jj = (jj + s[ii]) % 256;
            tmp = s[ii]; s[ii] = s[jj]; s[jj] = tmp;
            if (b >= drop) r.push_back(s[(s[ii] + s[jj]) % 256]);
        end
        return r;
    endfunction

    task automatic send_key(input bq_t key, output int c_h);
        c_h = cyc;
        check("key_ready_idle", {31'd0, o_key_ready}, 32'd1);
        for (int k = 0; k < key.size(); k++) begin
            key_valid = 1'b1;
            key_data  = key[k];
            key_last  = (k == key.size() - 1);
            if (k == key.size() - 1) c_h = cyc;
            tick();
        end
        key_valid = 1'b0;
        key_last  = 1'b0;
        key_data  = 8'd0;
        check("key_ready_after_last", {31'd0, o_key_ready}, 32'd0);
    endtask

    // Collect n bytes. stall_max=0 keeps ks_ready high; otherwise each byte
    // is held 0..stall_max cycles before being taken.
    task automatic collect(input int n, input int stall_max, input int c_h, output bq_t got);
        int stall;
        int budget;
        int first;
        int last_v;
        int hold_bad;
        int busy_bad;
        int gap_bad;
        logic [7:0] held;
        bit fresh;
        got = {};
        first = -1; last_v = 0; stall = 0;
        hold_bad = 0; busy_bad = 0; gap_bad = 0;
        fresh = 1'b1; held = 8'd0;
        budget = LAT + n * (stall_max + 6) + 64;
        while (got.size() < n && budget > 0) begin
            if (o_ks_valid) begin
                if (first < 0) begin
                    first = cyc;
                    if (o_busy !== 1'b0) busy_bad++;
                end
                if (fresh) begin
                    held  = o_ks_data;
                    fresh = 1'b0;
                    stall = (stall_max == 0) ? 0 : $urandom_range(stall_max, 0);
                    if (stall_max == 0 && got.size() > 0 && cyc - last_v != 4) gap_bad++;
                    last_v = cyc;
                end else if (o_ks_data !== held) begin
                    hold_bad++;
                end
                if (stall > 0) begin
                    ks_ready = 1'b0;
                    stall--;
                end else begin
                    ks_ready = 1'b1;
                    got.push_back(o_ks_data);
                    fresh = 1'b1;
                end
            end else begin
                if (first < 0 && o_busy !== 1'b1) busy_bad++;
                ks_ready = (stall_max == 0) ? 1'b1 : 1'($urandom_range(1, 0));
            end
            tick();
            budget--;
        end
        ks_ready = 1'b0;
        check("ks_count", got.size(), n);
        check("first_valid_latency", first - c_h, LAT);
        check("busy_profile", busy_bad, 0);
        check("ks_hold_stable", hold_bad, 0);
        if (stall_max == 0) check("ks_rate_4", gap_bad, 0);
    endtask

    task automatic cmp_stream(input string name, input bq_t got, input bq_t exp);
        for (int k = 0; k < exp.size(); k++) begin
            logic [7:0] a;
            a = (k < got.size()) ? got[k] : 8'bx;
            check($sformatf("%s[%0d]", name, k), {24'd0, a}, {24'd0, exp[k]});
        end
    endtask

    task automatic do_rekey();
        rekey = 1'b1;
        tick();
        rekey = 1'b0;
        check("rekey_key_ready", {31'd0, o_key_ready}, 32'd1);
        check("rekey_ks_valid",  {31'd0, o_ks_valid},  32'd0);
        check("rekey_busy",      {31'd0, o_busy},      32'd0);
        check("rekey_key_ovf",   {31'd0, o_key_ovf},   32'd0);
        check("rekey_ks_data",   {24'd0, o_ks_data},   32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_key_ready"}, {31'd0, o_key_ready}, 32'd1);
        check({tag, "_key_ovf"},   {31'd0, o_key_ovf},   32'd0);
        check({tag, "_busy"},      {31'd0, o_busy},      32'd0);
        check({tag, "_ks_valid"},  {31'd0, o_ks_valid},  32'd0);
        check({tag, "_ks_data"},   {24'd0, o_ks_data},   32'd0);
    endtask

    vec_t vecs [3];
    bq_t  kq;
    bq_t  got;
    bq_t  exp;
    bq_t  key_k;
    int   c_h;
    int   len;
    int   waited;

    initial begin
        vecs[0].key  = '{8'h4B, 8'h65, 8'h79, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[0].klen = 3;
        vecs[0].ks   = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
        vecs[0].nks  = 10;
        vecs[1].key  = '{8'h57, 8'h69, 8'h6B, 8'h69, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[1].klen = 4;
        vecs[1].ks   = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41, 8'hB7, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[1].nks  = 6;
        vecs[2].key  = '{8'h53, 8'h65, 8'h63, 8'h72, 8'h65, 8'h74, 8'h00, 8'h00};
        vecs[2].klen = 6;
        vecs[2].ks   = '{8'h04, 8'hD4, 8'h6B, 8'h05, 8'h3C, 8'hA8, 8'h7B, 8'h59, 8'h00, 8'h00};
        vecs[2].nks  = 8;
        key_k = '{8'h4B, 8'h65, 8'h79};

        rst = 1'b1; sel_b = 1'b0; rekey = 1'b0;
        key_valid = 1'b0; key_last = 1'b0; key_data = 8'd0; ks_ready = 1'b0;
        repeat (3) tick();
        check_reset_outputs("in_reset");
        rst = 1'b0;
        tick();
        check_reset_outputs("post_reset");

        // Known-answer table: Key, Wiki, Secret with rekey in between.
        for (int v = 0; v < 3; v++) begin
            kq = {};
            for (int k = 0; k < vecs[v].klen; k++) kq.push_back(vecs[v].key[k]);
            exp = {};
            for (int k = DROP; k < vecs[v].nks; k++) exp.push_back(vecs[v].ks[k]);
            send_key(kq, c_h);
            collect(exp.size(), 0, c_h, got);
            cmp_stream($sformatf("kat%0d", v), got, exp);
            check("kat_key_ovf", {31'd0, o_key_ovf}, 32'd0);
            do_rekey();
        end

        // Key with random consumer stalls.
        send_key(key_k, c_h);
        collect(10, 20, c_h, got);
        cmp_stream("stall_key", got, rc4_ref(key_k, 16, DROP, 10));
        do_rekey();

        // Overlong key on the 3-byte instance.
        sel_b = 1'b1;
        kq = '{8'h4B, 8'h65, 8'h79, 8'h78, 8'h78};
        send_key(kq, c_h);
        check("ovf_set", {31'd0, o_key_ovf}, 32'd1);
        collect(8, 0, c_h, got);
        cmp_stream("ovf_stream", got, rc4_ref(key_k, 16, DROP, 8));
        check("ovf_sticky", {31'd0, o_key_ovf}, 32'd1);
        do_rekey();
        sel_b = 1'b0;

        // Async reset in the middle of KSA.
        send_key(key_k, c_h);
        repeat (400) tick();
        check("busy_in_ksa", {31'd0, o_busy}, 32'd1);
        rst = 1'b1;
        #2;
        check_reset_outputs("rst_in_ksa");
        tick();
        rst = 1'b0;
        tick();
        check_reset_outputs("rst_release");
        send_key(key_k, c_h);
        collect(3, 0, c_h, got);
        cmp_stream("after_rst", got, rc4_ref(key_k, 16, DROP, 3));

        // Rekey while a byte is held in P4 with ks_ready low.
        waited = 0;
        while (!o_ks_valid && waited < 20) begin
            tick();
            waited++;
        end
        tick();
        check("p4_holding", {31'd0, o_ks_valid}, 32'd1);
        do_rekey();
        send_key(key_k, c_h);
        collect(3, 0, c_h, got);
        cmp_stream("after_rekey_p4", got, rc4_ref(key_k, 16, DROP, 3));
        do_rekey();

        // Random keys (some overlong, one all-zero) with random stalls.
        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(20, 1);
            kq = {};
            for (int k = 0; k < len; k++) kq.push_back((r == 0) ? 8'd0 : 8'($urandom_range(255, 0)));
            send_key(kq, c_h);
            check("rand_key_ovf", {31'd0, o_key_ovf}, {31'd0, (len > 16)});
            collect(8, 5, c_h, got);
            cmp_stream($sformatf("rand%0d", r), got, rc4_ref(kq, 16, DROP, 8));
            do_rekey();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
